// File: rtl/tetris_input_pkg.sv
// Shared key indices, action FSM states and default 50 MHz timing for the Tetris input front end.
package tetris_input_pkg;

  localparam int unsigned KEY_RIGHT  = 0;
  localparam int unsigned KEY_LEFT   = 1;
  localparam int unsigned KEY_DOWN   = 2;
  localparam int unsigned KEY_ROTATE = 3;

  localparam int unsigned CLK_HZ = 50_000_000;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 50;       // 20 ms
  localparam int DEFAULT_REPEAT_DELAY    = (CLK_HZ / 10) * 3; // 300 ms
  localparam int DEFAULT_REPEAT_RATE     = CLK_HZ / 10;       // 100 ms

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_FIRST,
    KEY_REPEAT,
    KEY_LOCK
  } key_state_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button: synchroniser chain followed by a stable-count debouncer.
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic key_held
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   stable;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      sync     <= '1;
      stable   <= 1'b1;
      cnt      <= '0;
      key_held <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], key_n};
      key_held <= ~stable;
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Unregistered view lets the action FSM pulse in the same cycle key_held rises.
  assign level = ~stable;

endmodule

// File: rtl/tetris_key_conditioner.sv
// Turns the four raw DE2 keys into one-cycle game actions with auto-repeat, pause and left/right lockout.
module tetris_key_conditioner
  import tetris_input_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  input  logic       pause,
  output logic       move_right,
  output logic       move_left,
  output logic       move_down,
  output logic       rotate,
  output logic [3:0] key_held
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
  localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LOAD  = RW'(REPEAT_RATE - 1);

  logic [3:0] level;
  logic [3:0] pulse;
  logic       conflict;

  assign conflict = level[KEY_LEFT] & level[KEY_RIGHT];

  for (genvar g = 0; g < 4; g++) begin : g_key
    localparam bit REPEATS    = (g != KEY_ROTATE);
    localparam bit HORIZONTAL = (g == KEY_LEFT) || (g == KEY_RIGHT);

    key_state_e    state;
    logic [RW-1:0] rep_cnt;
    logic          pulse_q;
    logic          blocked;

    key_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_50  (clk_50),
      .reset_n (reset_n),
      .key_n   (key_n[g]),
      .level   (level[g]),
      .key_held(key_held[g])
    );

    assign blocked = pause | (HORIZONTAL & conflict);

    // Release outranks lockout so a locked key only recovers through IDLE.
    always_ff @(posedge clk_50) begin
      if (!reset_n) begin
        state   <= KEY_IDLE;
        rep_cnt <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (!level[g]) begin
          state <= KEY_IDLE;
        end else if (blocked) begin
          state <= KEY_LOCK;
        end else begin
          case (state)
            KEY_IDLE: begin
              pulse_q <= 1'b1;
              rep_cnt <= DELAY_LOAD;
              state   <= KEY_FIRST;
            end
            KEY_FIRST: begin
              if (REPEATS) begin
                if (rep_cnt == '0) begin
                  pulse_q <= 1'b1;
                  rep_cnt <= RATE_LOAD;
                  state   <= KEY_REPEAT;
                end else begin
                  rep_cnt <= rep_cnt - RW'(1);
                end
              end
            end
            KEY_REPEAT: begin
              if (rep_cnt == '0) begin
                pulse_q <= 1'b1;
                rep_cnt <= RATE_LOAD;
              end else begin
                rep_cnt <= rep_cnt - RW'(1);
              end
            end
            KEY_LOCK: state <= KEY_LOCK;
            default:  state <= KEY_IDLE;
          endcase
        end
      end
    end

    assign pulse[g] = pulse_q;
  end

  assign move_right = pulse[KEY_RIGHT];
  assign move_left  = pulse[KEY_LEFT];
  assign move_down  = pulse[KEY_DOWN];
  assign rotate     = pulse[KEY_ROTATE];

endmodule
